// File: rtl/logic_shift_unit_pkg.sv
// Shared definitions for the logic/shift unit: default width, opcode and FSM state enums.
package logic_shift_unit_pkg;

    localparam int NBITS = 32;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_AND  = 4'b0001,
        OP_OR   = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_NOTB = 4'b0100,
        OP_NOR  = 4'b0101,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_ROL  = 4'b1011
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for the four opcodes that go through the iterative shifter
    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == OP_SLL) || (code == OP_SRL) ||
               (code == OP_SRA) || (code == OP_ROL);
    endfunction

endpackage

// File: rtl/logic_shift_unit_shift_step.sv
// Single-bit step of the iterative shifter: one position of SLL/SRL/SRA/ROL.
module shift_step
    import logic_shift_unit_pkg::*;
#(
    parameter int WIDTH = NBITS
) (
    input  logic [WIDTH-1:0] value,
    input  op_t              op,
    output logic [WIDTH-1:0] next_value
);

    // Move the value by exactly one bit according to the shift opcode
    always_comb begin
        next_value = value;
        case (op)
            OP_SLL:  next_value = {value[WIDTH-2:0], 1'b0};
            OP_SRL:  next_value = {1'b0, value[WIDTH-1:1]};
            OP_SRA:  next_value = {value[WIDTH-1], value[WIDTH-1:1]};
            OP_ROL:  next_value = {value[WIDTH-2:0], value[WIDTH-1]};
            default: next_value = value;
        endcase
    end

endmodule

// File: rtl/logic_shift_unit.sv
// Logic/shift unit: single-cycle bitwise ops, one-bit-per-cycle shifts and rotates,
// valid/ready handshake on both sides with a registered result.
module logic_shift_unit
    import logic_shift_unit_pkg::*;
#(
    parameter int WIDTH = NBITS,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             long_shift;
    logic             last_step;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   cnt_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] step_val;
    op_t              sop;
    op_t              sop_nxt;
    logic [WIDTH-1:0] logic_res;
    logic             illegal;
    logic [WIDTH-1:0] y_nxt;
    logic             zero_nxt;
    logic             err_nxt;

    assign long_shift = is_shift_op(op) && (shamt != '0);
    assign last_step  = (cnt <= SHW'(1));

    shift_step #(.WIDTH(WIDTH)) u_shift_step (
        .value      (sreg),
        .op         (sop),
        .next_value (step_val)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and handshake outputs; an accept in DONE restarts as from IDLE
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE:  in_ready = 1'b1;
            ST_SHIFT: if (last_step) state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
        accept = in_valid && in_ready;
        if (accept) state_nxt = long_shift ? ST_SHIFT : ST_DONE;
    end

    // Single-cycle result: bitwise ops, pass-through for zero-amount shifts, illegal flag
    always_comb begin
        logic_res = '0;
        illegal   = 1'b0;
        case (op)
            OP_NOP:  logic_res = '0;
            OP_AND:  logic_res = a & b;
            OP_OR:   logic_res = a | b;
            OP_XOR:  logic_res = a ^ b;
            OP_NOTB: logic_res = ~b;
            OP_NOR:  logic_res = ~(a | b);
            OP_SLL, OP_SRL, OP_SRA, OP_ROL: logic_res = a;
            default: illegal = 1'b1;
        endcase
    end

    // Datapath next values: load on accept, step while shifting, hold otherwise
    always_comb begin
        sreg_nxt = sreg;
        cnt_nxt  = cnt;
        sop_nxt  = sop;
        y_nxt    = y;
        zero_nxt = zero;
        err_nxt  = err;
        if (accept) begin
            if (long_shift) begin
                sreg_nxt = a;
                cnt_nxt  = shamt;
                sop_nxt  = op_t'(op);
            end else begin
                y_nxt    = logic_res;
                zero_nxt = (logic_res == '0);
                err_nxt  = illegal;
                cnt_nxt  = '0;
            end
        end else if (state == ST_SHIFT) begin
            sreg_nxt = step_val;
            cnt_nxt  = cnt - SHW'(1);
            // The final step is written straight into y so DONE follows N shift cycles
            if (last_step) begin
                y_nxt    = step_val;
                zero_nxt = (step_val == '0);
                err_nxt  = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
            sop  <= OP_NOP;
            y    <= '0;
            zero <= 1'b0;
            err  <= 1'b0;
        end else begin
            sreg <= sreg_nxt;
            cnt  <= cnt_nxt;
            sop  <= sop_nxt;
            y    <= y_nxt;
            zero <= zero_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: doc/logic_shift_unit.md
LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

Interface
REQ-001 The block SHALL use one clock, with an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default NBITS, SHALL set the operand and result width in bits.
REQ-003 Parameter SHW, default $clog2(WIDTH), SHALL set the shift-amount width in bits.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous reset, active low.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  request can be accepted this cycle.
REQ-008 op  in  4  opcode.
REQ-009 a  in  WIDTH  operand A (also the value being shifted).
REQ-010 b  in  WIDTH  operand B.
REQ-011 shamt  in  SHW  shift or rotate amount.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer takes the result.
REQ-014 y  out  WIDTH  registered result.
REQ-015 zero  out  1  y==0; meaningful only while out_valid=1.
REQ-016 err  out  1  illegal opcode; meaningful only while out_valid=1.
REQ-017 busy  out  1  state is not IDLE.

Function
REQ-018 Opcodes SHALL be:
- 0000 NOP: y=0.
- 0001 AND: a&b.
- 0010 OR: a|b.
- 0011 XOR: a^b.
- 0100 NOTB: ~b.
- 0101 NOR: ~(a|b).
- 1000 SLL.
- 1001 SRL.
- 1010 SRA.
- 1011 ROL.
REQ-019 Any other opcode SHALL produce y=0, err=1, with latency 1.
REQ-020 The FSM states SHALL be IDLE, SHIFT and DONE.
REQ-021 A request SHALL be accepted on the cycle where in_valid && in_ready.
- op, a, b and shamt are sampled on that cycle only.
- Later input changes are ignored.
REQ-022 in_ready SHALL be 1 in IDLE and (out_ready) in DONE, and 0 in SHIFT.
REQ-023 A logic opcode, an illegal opcode, or a shift with shamt=0 SHALL go to DONE on the next edge with y loaded; latency is 1 cycle.
- For a shift with shamt=0, y=a.
REQ-024 A shift with shamt=N>0 SHALL load an internal register with a and a down-counter with N, then go to SHIFT.
REQ-025 In SHIFT, each cycle SHALL move the register by exactly one bit and decrement the counter.
- SLL: zero fill.
- SRL: zero fill.
- SRA: MSB replicated.
- ROL: MSB wraps to LSB.
REQ-026 When the counter reaches 0, the FSM SHALL go to DONE; out_valid rises exactly N+1 cycles after accept.
REQ-027 In DONE, out_valid=1 and y, zero and err SHALL stay stable until out_ready=1.
REQ-028 The DONE exit SHALL be:
- out_ready=1 and no new accept: go to IDLE.
- out_ready=1 with a simultaneous accept: process the new request as from IDLE, with no bubble.
REQ-029 zero and err SHALL be registered in the same cycle as y.
REQ-030 Results SHALL be truncated to WIDTH; no carry or overflow output exists.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 rst_n low SHALL immediately force:
- state=IDLE, counter=0.
- y=0, zero=0, err=0.
- out_valid=0, busy=0, in_ready=1.
REQ-033 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no out_valid is produced for it.
REQ-034 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-035 The opcode enum (op_t, 4 bits) and the FSM state enum SHALL live in the shared definitions package beside NBITS.
REQ-036 One sub-module, shift_step, SHALL hold the combinational one-bit SLL/SRL/SRA/ROL step.
- Inputs: value, op.
- Output: next value.
REQ-037 All logic-op results SHALL be computed in the parent module.

Verification (WIDTH=32)
REQ-038 AND, a=F0F0F0F0, b=0FF00FF0 -> y=00F000F0, zero=0, out_valid 1 cycle after accept.
REQ-039 XOR, a=b=12345678 -> y=0, zero=1.
REQ-040 Illegal op 0111 -> y=0, err=1.
REQ-041 SRA, a=80000000, shamt=4 -> y=F8000000 with out_valid exactly 5 cycles after accept.
- in_ready=0 while in SHIFT.
REQ-042 ROL, a=80000001, shamt=31 -> y=C0000000 after 32 cycles.
REQ-043 SLL, shamt=0, a=DEADBEEF -> y=DEADBEEF, latency 1.
REQ-044 Hold out_ready=0 for 3 cycles in DONE -> y stable throughout.
- Then assert out_ready together with a new OR request.
- The OR is accepted on that same edge, and its result appears on the next cycle.
REQ-045 SRL, shamt=20; drop rst_n on cycle 5 -> out_valid never asserted for that operation.
- After release, busy=0 and in_ready=1.
